store_buffer: RTL and testbench

//   Posted-write FIFO between the MEM pipeline stage and data memory (mem_data).
//   - Stores retire into the buffer in one cycle; drained to memory when the port is free.
//   - Loads get priority on the memory port.
//   - A load whose address matches a resident store gets the youngest matching data forwarded.
//   - Owns the address/write mux that drives mem_data.

---
 rtl/store_buffer_pkg.sv | 14 +
 rtl/sb_match_youngest.sv | 37 +++
 rtl/store_buffer.sv | 163 ++++++++++++++++
 tb/tb_store_buffer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared widths, RiSC-16 memory size and memory-port mode encoding for the store buffer.
// Optional store coalescing is enabled by defining STORE_BUF_COALESCE_EN.
package store_buffer_pkg;
  localparam int unsigned SB_WORD_LEN      = 16;
  localparam int unsigned SB_ADDR_LEN      = 10;
  localparam int unsigned SB_DEPTH         = 4;
  localparam int unsigned RISC16_MEM_WORDS = 1 << SB_ADDR_LEN;

  typedef enum logic [1:0] {
    SB_IDLE  = 2'd0,
    SB_DRAIN = 2'd1,
    SB_LOAD  = 2'd2
  } sb_port_e;
endpackage

// File: rtl/sb_match_youngest.sv
// Compares an address against every valid entry and selects the youngest match,
// walking entries oldest-to-youngest starting from the head pointer.
module sb_match_youngest
  import store_buffer_pkg::*;
#(
  parameter int unsigned p_WORD_LEN = SB_WORD_LEN,
  parameter int unsigned p_ADDR_LEN = SB_ADDR_LEN,
  parameter int unsigned p_DEPTH    = SB_DEPTH
) (
  input  logic [p_ADDR_LEN-1:0]                i_addr,
  input  logic [$clog2(p_DEPTH)-1:0]           i_head,
  input  logic [p_DEPTH-1:0]                   i_valid,
  input  logic [p_DEPTH-1:0][p_ADDR_LEN-1:0]   i_addrs,
  input  logic [p_DEPTH-1:0][p_WORD_LEN-1:0]   i_data,
  output logic                                 o_hit,
  output logic [$clog2(p_DEPTH)-1:0]           o_idx,
  output logic [p_WORD_LEN-1:0]                o_data
);
  localparam int unsigned PW = $clog2(p_DEPTH);

  // Later (younger) matches overwrite earlier ones; pointer wrap is free since depth is 2^n.
  always_comb begin
    logic [PW-1:0] v_idx;
    v_idx  = '0;
    o_hit  = 1'b0;
    o_idx  = '0;
    o_data = '0;
    for (int unsigned age = 0; age < p_DEPTH; age++) begin
      v_idx = i_head + PW'(age);
      if (i_valid[v_idx] && (i_addrs[v_idx] == i_addr)) begin
        o_hit  = 1'b1;
        o_idx  = v_idx;
        o_data = i_data[v_idx];
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer in front of mem_data: FIFO of retired stores, load forwarding,
// load-priority memory port mux. Define STORE_BUF_COALESCE_EN to merge same-address stores.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned p_WORD_LEN = SB_WORD_LEN,
  parameter int unsigned p_ADDR_LEN = SB_ADDR_LEN,
  parameter int unsigned p_DEPTH    = SB_DEPTH
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_st_valid,
  input  logic [p_ADDR_LEN-1:0]          i_st_addr,
  input  logic [p_WORD_LEN-1:0]          i_st_data,
  output logic                           o_st_ready,
  input  logic                           i_ld_valid,
  input  logic [p_ADDR_LEN-1:0]          i_ld_addr,
  output logic                           o_ld_hit,
  output logic [p_WORD_LEN-1:0]          o_ld_data,
  output logic                           o_mem_wr_en,
  output logic [p_ADDR_LEN-1:0]          o_mem_addr,
  output logic [p_WORD_LEN-1:0]          o_mem_wr_data,
  output logic [$clog2(p_DEPTH+1)-1:0]   o_count,
  output logic                           o_empty,
  output logic                           o_full
);
  localparam int unsigned PW = $clog2(p_DEPTH);
  localparam int unsigned CW = $clog2(p_DEPTH + 1);

  logic [PW-1:0]                       r_head;
  logic [PW-1:0]                       r_tail;
  logic [CW-1:0]                       r_count;
  logic [p_DEPTH-1:0]                  r_valid;
  logic [p_DEPTH-1:0][p_ADDR_LEN-1:0]  r_addr;
  logic [p_DEPTH-1:0][p_WORD_LEN-1:0]  r_data;

  sb_port_e             w_port;
  logic                 w_drain;
  logic                 w_push;
  logic                 w_alloc;
  logic                 w_merge;
  logic [PW-1:0]        w_merge_idx;
  logic                 w_fwd_hit;
  logic [PW-1:0]        w_fwd_idx;
  logic [p_WORD_LEN-1:0] w_fwd_data;
  logic                 w_unused;

  assign o_count = r_count;
  assign o_empty = (r_count == CW'(0));
  assign o_full  = (r_count == CW'(p_DEPTH));

  sb_match_youngest #(
    .p_WORD_LEN (p_WORD_LEN),
    .p_ADDR_LEN (p_ADDR_LEN),
    .p_DEPTH    (p_DEPTH)
  ) u_fwd_match (
    .i_addr  (i_ld_addr),
    .i_head  (r_head),
    .i_valid (r_valid),
    .i_addrs (r_addr),
    .i_data  (r_data),
    .o_hit   (w_fwd_hit),
    .o_idx   (w_fwd_idx),
    .o_data  (w_fwd_data)
  );

  assign o_ld_hit  = w_fwd_hit;
  assign o_ld_data = w_fwd_data;

  // Port owner: a load always wins, otherwise drain the head entry if one exists.
  always_comb begin
    w_port = SB_IDLE;
    if (i_ld_valid) begin
      w_port = SB_LOAD;
    end else if (!o_empty) begin
      w_port = SB_DRAIN;
    end
  end

  assign w_drain = (w_port == SB_DRAIN);

  always_comb begin
    o_mem_wr_en   = 1'b0;
    o_mem_addr    = o_empty ? '0 : r_addr[r_head];
    o_mem_wr_data = o_empty ? '0 : r_data[r_head];
    case (w_port)
      SB_LOAD:  o_mem_addr  = i_ld_addr;
      SB_DRAIN: o_mem_wr_en = 1'b1;
      default:  ;
    endcase
  end

  assign w_push = i_st_valid && o_st_ready;

`ifdef STORE_BUF_COALESCE_EN
  logic [p_DEPTH-1:0]    w_coal_valid;
  logic                  w_coal_hit;
  logic [PW-1:0]         w_coal_idx;
  logic [p_WORD_LEN-1:0] w_coal_data;

  // The head leaving this cycle must not absorb a new store; its write is already in flight.
  always_comb begin
    w_coal_valid = r_valid;
    if (w_drain) begin
      w_coal_valid[r_head] = 1'b0;
    end
  end

  sb_match_youngest #(
    .p_WORD_LEN (p_WORD_LEN),
    .p_ADDR_LEN (p_ADDR_LEN),
    .p_DEPTH    (p_DEPTH)
  ) u_coal_match (
    .i_addr  (i_st_addr),
    .i_head  (r_head),
    .i_valid (w_coal_valid),
    .i_addrs (r_addr),
    .i_data  (r_data),
    .o_hit   (w_coal_hit),
    .o_idx   (w_coal_idx),
    .o_data  (w_coal_data)
  );

  assign o_st_ready  = !o_full || w_coal_hit;
  assign w_alloc     = w_push && !w_coal_hit;
  assign w_merge     = w_push && w_coal_hit;
  assign w_merge_idx = w_coal_idx;
  assign w_unused    = ^{w_fwd_idx, w_coal_data};
`else
  assign o_st_ready  = !o_full;
  assign w_alloc     = w_push;
  assign w_merge     = 1'b0;
  assign w_merge_idx = '0;
  assign w_unused    = ^w_fwd_idx;
`endif

  // Entry storage, pointers and occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      if (w_drain) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PW'(1);
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_addr[r_tail]  <= i_st_addr;
        r_data[r_tail]  <= i_st_data;
        r_tail          <= r_tail + PW'(1);
      end
      if (w_merge) begin
        r_data[w_merge_idx] <= i_st_data;
      end
      r_count <= r_count + CW'(w_alloc) - CW'(w_drain);
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Randomized scoreboard bench for store_buffer: a queue model of the buffer predicts
// flags/forwarding per cycle and the drain order checked by a memory-write monitor.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int W  = SB_WORD_LEN;
  localparam int A  = SB_ADDR_LEN;
  localparam int D  = SB_DEPTH;
  localparam int CW = $clog2(SB_DEPTH + 1);

  typedef struct {
    logic [A-1:0] addr;
    logic [W-1:0] data;
  } ent_t;

  logic          clk;
  logic          rst_n;
  logic          st_valid;
  logic [A-1:0]  st_addr;
  logic [W-1:0]  st_data;
  logic          st_ready;
  logic          ld_valid;
  logic [A-1:0]  ld_addr;
  logic          ld_hit;
  logic [W-1:0]  ld_data;
  logic          mem_wr_en;
  logic [A-1:0]  mem_addr;
  logic [W-1:0]  mem_wr_data;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;

  ent_t         model_q[$];
  ent_t         exp_wr[$];
  logic [W-1:0] tb_mem  [RISC16_MEM_WORDS];
  logic [W-1:0] ref_mem [RISC16_MEM_WORDS];
  int           n_checks = 0;
  int           n_errors = 0;

  store_buffer dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_st_valid    (st_valid),
    .i_st_addr     (st_addr),
    .i_st_data     (st_data),
    .o_st_ready    (st_ready),
    .i_ld_valid    (ld_valid),
    .i_ld_addr     (ld_addr),
    .o_ld_hit      (ld_hit),
    .o_ld_data     (ld_data),
    .o_mem_wr_en   (mem_wr_en),
    .o_mem_addr    (mem_addr),
    .o_mem_wr_data (mem_wr_data),
    .o_count       (count),
    .o_empty       (empty),
    .o_full        (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // mem_data stand-in plus scoreboard: every write must be the next expected drain.
  always @(negedge clk) begin
    if (rst_n && mem_wr_en) begin
      if (exp_wr.size() == 0) begin
        chk("unexpected_mem_write", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        ent_t e;
        e = exp_wr.pop_front();
        chk("drain_addr", 32'(mem_addr), 32'(e.addr));
        chk("drain_data", 32'(mem_wr_data), 32'(e.data));
      end
      tb_mem[mem_addr] = mem_wr_data;
    end
  end

  // One cycle: drive inputs, check outputs against the model, then advance the model.
  task automatic step(input logic ldv, input logic [A-1:0] lda,
                      input logic stv, input logic [A-1:0] sta, input logic [W-1:0] std);
    int           sz;
    int           midx;
    bit           drain;
    bit           match;
    bit           ready;
    bit           hit;
    logic [W-1:0] fwd;
    ld_valid = ldv;
    ld_addr  = lda;
    st_valid = stv;
    st_addr  = sta;
    st_data  = std;
    sz    = model_q.size();
    drain = (sz > 0) && !ldv;
    match = 1'b0;
    midx  = 0;
`ifdef STORE_BUF_COALESCE_EN
    for (int i = (drain ? 1 : 0); i < sz; i++) begin
      if (model_q[i].addr == sta) begin
        match = 1'b1;
        midx  = i;
      end
    end
`endif
    ready = (sz < D) || match;
    hit   = 1'b0;
    fwd   = '0;
    for (int i = 0; i < sz; i++) begin
      if (model_q[i].addr == lda) begin
        hit = 1'b1;
        fwd = model_q[i].data;
      end
    end
    #1;
    chk("count", 32'(count), 32'(sz));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("full", 32'(full), 32'(sz == D));
    chk("st_ready", 32'(st_ready), 32'(ready));
    chk("mem_wr_en", 32'(mem_wr_en), 32'(drain));
    chk("ld_hit", 32'(ld_hit), 32'(hit));
    chk("ld_data", 32'(ld_data), 32'(fwd));
    if (ldv) chk("mem_addr_load", 32'(mem_addr), 32'(lda));
    if (drain) begin
      exp_wr.push_back(model_q[0]);
      ref_mem[model_q[0].addr] = model_q[0].data;
    end
    if (stv && ready && match) model_q[midx].data = std;
    if (drain) void'(model_q.pop_front());
    if (stv && ready && !match) model_q.push_back('{sta, std});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < RISC16_MEM_WORDS; i++) begin
      tb_mem[i]  = '0;
      ref_mem[i] = '0;
    end
    rst_n    = 1'b0;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    ld_valid = 1'b0;
    ld_addr  = '0;
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_st_ready", 32'(st_ready), 1);
    chk("rst_mem_wr_en", 32'(mem_wr_en), 0);
    chk("rst_ld_hit", 32'(ld_hit), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-fill: three stores parked behind a load, then discarded.
    step(1'b1, 10'd100, 1'b1, 10'd30, 16'h1234);
    step(1'b1, 10'd100, 1'b1, 10'd31, 16'h2345);
    step(1'b1, 10'd100, 1'b1, 10'd32, 16'h3456);
    ld_valid = 1'b0;
    ld_addr  = 10'd30;
    st_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("midrst_count", 32'(count), 0);
    chk("midrst_empty", 32'(empty), 1);
    chk("midrst_mem_wr_en", 32'(mem_wr_en), 0);
    chk("midrst_ld_hit", 32'(ld_hit), 0);
    model_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Drain of a single store.
    step(1'b0, '0, 1'b1, 10'd5, 16'hBEEF);
    chk("drain_pending_addr", 32'(mem_addr), 5);
    idle();
    idle();
    chk("drain_mem5", 32'(tb_mem[5]), 32'hBEEF);

    // Load priority with two resident entries.
    step(1'b1, 10'd50, 1'b1, 10'd1, 16'h0101);
    step(1'b1, 10'd51, 1'b1, 10'd2, 16'h0202);
    for (int i = 0; i < 3; i++) step(1'b1, 10'(60 + i), 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) idle();

    // Forwarding picks the youngest of two same-address stores.
    step(1'b1, 10'd7, 1'b1, 10'd7, 16'h1111);
    step(1'b1, 10'd7, 1'b1, 10'd7, 16'h2222);
    step(1'b1, 10'd7, 1'b0, '0, '0);
    step(1'b1, 10'd8, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) idle();

    // Fill to full under a load stall, overflow attempt, drain, then wrap.
    for (int i = 0; i < 4; i++) step(1'b1, 10'd99, 1'b1, 10'(10 + i), 16'(16'hA000 + i));
    step(1'b1, 10'd99, 1'b1, 10'd14, 16'hDEAD);
    chk("full_flag", 32'(full), 1);
    for (int i = 0; i < 5; i++) idle();
    for (int i = 0; i < 4; i++) step(1'b1, 10'd99, 1'b1, 10'(20 + i), 16'(16'hB000 + i));
    for (int i = 0; i < 5; i++) idle();

    // Same-address stores while loads block the port.
    step(1'b1, 10'd99, 1'b1, 10'd3, 16'h000A);
    step(1'b1, 10'd99, 1'b1, 10'd9, 16'h000B);
    step(1'b1, 10'd99, 1'b1, 10'd3, 16'h000C);
`ifdef STORE_BUF_COALESCE_EN
    chk("coalesce_count", 32'(count), 2);
`else
    chk("coalesce_count", 32'(count), 3);
`endif
    for (int i = 0; i < 4; i++) idle();

    // Random traffic over a small address window so hits and merges are common.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 9) < 4), 10'($urandom_range(0, 15)),
           ($urandom_range(0, 9) < 6), 10'($urandom_range(0, 15)), 16'($urandom));
    end

    for (int n = 0; n < 20 && model_q.size() > 0; n++) idle();
    chk("final_model_empty", 32'(model_q.size()), 0);
    chk("final_dut_empty", 32'(empty), 1);
    chk("final_scoreboard_empty", 32'(exp_wr.size()), 0);
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("mem[%0d]", i), 32'(tb_mem[i]), 32'(ref_mem[i]));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
